// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter
//   Round-robin arbiter and sequencer that shares one 8-bit multifunction
//   barrel shifter among N_REQ requesters. One request is accepted in IDLE,
//   shifted and registered in EXEC, and presented in RESP until the consumer
//   takes it.
//
// Parameters
//   N_REQ      number of requesters (2..8)
//   ID_W       width of the response ID
//
// Ports
//   clk        clock, all logic on rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester request valid
//   req_ready  per-requester accept (one-hot or zero, combinational in IDLE)
//   req_data   8-bit operand per requester, requester i at [8i+7:8i]
//   req_amt    3-bit shift amount per requester, requester i at [3i+2:3i]
//   req_mode   2-bit mode per requester: 00 shl, 01 shr, 10 rotl, 11 rotr
//   rsp_valid  result valid
//   rsp_ready  consumer accepts result
//   rsp_data   shifted result
//   rsp_id     index of the requester owning rsp_data
//   grant_cnt  16-bit saturating accept counter per requester
//              (only when BSA_STATS_EN is defined)
//
// Optional feature macro: BSA_STATS_EN
module barrel_shift_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [3*N_REQ-1:0]   req_amt,
  input  logic [2*N_REQ-1:0]   req_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id
`ifdef BSA_STATS_EN
  ,
  output logic [16*N_REQ-1:0]  grant_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] search_idx;
  logic [ID_W-1:0] next_ptr;
  logic            any_valid;
  logic            accept;
  logic [7:0]      sel_data;
  logic [2:0]      sel_amt;
  logic [1:0]      sel_mode;
  logic [7:0]      cap_data;
  logic [2:0]      cap_amt;
  logic [1:0]      cap_mode;
  logic [ID_W-1:0] cap_id;

  // Multifunction 8-bit shift. Rotates shift a doubled copy of the operand
  // so a rotate by 0 naturally returns the operand instead of 0.
  function automatic logic [7:0] shift8(input logic [7:0] d,
                                        input logic [2:0] s,
                                        input logic [1:0] mode);
    logic [15:0] dbl;
    logic [7:0]  res;
    dbl = {d, d};
    res = d;
    case (mode)
      2'b00: res = d << s;
      2'b01: res = d >> s;
      2'b10: begin
        dbl = dbl << s;
        res = dbl[15:8];
      end
      default: begin
        dbl = dbl >> s;
        res = dbl[7:0];
      end
    endcase
    return res;
  endfunction

  // Round-robin search: walk downward from the farthest offset so the last
  // match written is the first valid requester at or after rr_ptr.
  always_comb begin
    any_valid  = 1'b0;
    winner     = '0;
    search_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      search_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[search_idx]) begin
        any_valid = 1'b1;
        winner    = search_idx;
      end
    end
  end

  assign accept   = (state == IDLE) && any_valid;
  assign next_ptr = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

  // Steer the winner's fields and raise its ready bit only while idle.
  always_comb begin
    sel_data  = '0;
    sel_amt   = '0;
    sel_mode  = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_data     = req_data[8*i +: 8];
        sel_amt      = req_amt[3*i +: 3];
        sel_mode     = req_mode[2*i +: 2];
        req_ready[i] = accept;
      end
    end
  end

  // Sequencer: capture in IDLE, compute in EXEC, hold in RESP. Reset drops
  // any in-flight transaction without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cap_data  <= '0;
      cap_amt   <= '0;
      cap_mode  <= '0;
      cap_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            cap_data <= sel_data;
            cap_amt  <= sel_amt;
            cap_mode <= sel_mode;
            cap_id   <= winner;
            rr_ptr   <= next_ptr;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= shift8(cap_data, cap_amt, cap_mode);
          rsp_id    <= cap_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef BSA_STATS_EN
  // Per-requester accept counters, saturating so a long run never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < N_REQ; i++) begin
        if ((winner == ID_W'(i)) && (grant_cnt[16*i +: 16] != 16'hFFFF)) begin
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb_barrel_shift_arbiter
//   Self-checking bench for barrel_shift_arbiter with N_REQ=4. Expected
//   results come from an arithmetic shift model and a pointer-based
//   round-robin model kept here.
module tb_barrel_shift_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [8*N_REQ-1:0]  req_data;
  logic [3*N_REQ-1:0]  req_amt;
  logic [2*N_REQ-1:0]  req_mode;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [7:0]          rsp_data;
  logic [ID_W-1:0]     rsp_id;
`ifdef BSA_STATS_EN
  logic [16*N_REQ-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  int model_cnt [N_REQ];
  logic [7:0] fd [N_REQ];
  logic [2:0] fa [N_REQ];
  logic [1:0] fm [N_REQ];

  typedef struct {
    int         id;
    logic [7:0] d;
    logic [2:0] amt;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  barrel_shift_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_mode  (req_mode),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef BSA_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Shift reference built from multiplication and division by powers of two.
  function automatic logic [7:0] refShift(input logic [7:0] d, input int s, input int mode);
    int v, p, r;
    v = int'(d);
    p = 1 << s;
    case (mode)
      0: r = (v * p) % 256;
      1: r = v / p;
      2: r = (v * p) % 256 + v / (256 / p);
      default: r = v / p + (v * (256 / p)) % 256;
    endcase
    return 8'(r);
  endfunction

  // First valid requester at or after the pointer, wrapping; -1 if none.
  function automatic int refWinner(input logic [N_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
    fd[id] = d;
    fa[id] = a;
    fm[id] = m;
    req_data[8*id +: 8] = d;
    req_amt[3*id +: 3]  = a;
    req_mode[2*id +: 2] = m;
  endtask

  task automatic doReset();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < N_REQ; i++) model_cnt[i] = 0;
  endtask

  // Waits (bounded) at negedges for any req_ready; returns 1 if seen.
  task automatic waitReady(output bit got);
    got = 1'b0;
    for (int w = 0; w < 12; w++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // One single-requester transaction with latency and result checks.
  task automatic runOne(input int id, input logic [7:0] d, input logic [2:0] a,
                        input logic [1:0] m, input logic [7:0] exp, input string tag);
    bit got;
    applyStimulus(id, d, a, m);
    req_valid = '0;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b0;
    waitReady(got);
    if (!got) begin
      checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
    @(posedge clk);
    #1 req_valid = '0;
    model_ptr = (id + 1) % N_REQ;
    model_cnt[id]++;
    @(negedge clk);
    checkOutput({tag, "_valid_t1"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid_t2"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(rsp_data), 32'(exp));
    checkOutput({tag, "_id"}, 32'(rsp_id), 32'(id));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lastCycle, grants, w, stall;
    int expIds[$];
    logic [7:0] expData[$];
    logic [7:0] expv, holdData;
    logic [N_REQ-1:0] mask;
    bit got;

    vecs[0] = '{0, 8'h96, 3'd3, 2'b00, 8'hB0};
    vecs[1] = '{2, 8'hA5, 3'd3, 2'b01, 8'h14};
    vecs[2] = '{2, 8'hA5, 3'd3, 2'b10, 8'h2D};
    vecs[3] = '{2, 8'hA5, 3'd3, 2'b11, 8'hB4};
    vecs[4] = '{2, 8'hA5, 3'd0, 2'b00, 8'hA5};
    vecs[5] = '{2, 8'hA5, 3'd0, 2'b01, 8'hA5};
    vecs[6] = '{2, 8'hA5, 3'd0, 2'b10, 8'hA5};
    vecs[7] = '{2, 8'hA5, 3'd0, 2'b11, 8'hA5};

    req_data = '0;
    req_amt  = '0;
    req_mode = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fd[i] = '0; fa[i] = '0; fm[i] = '0;
    end
    doReset();

    // Reset state
    @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
`ifdef BSA_STATS_EN
    checkOutput("reset_grant_cnt", 32'(grant_cnt == '0), 32'd1);
`endif
    @(posedge clk);
    #1;

    // Table-driven single requests and mode sweep
    for (int v = 0; v < 8; v++) begin
      runOne(vecs[v].id, vecs[v].d, vecs[v].amt, vecs[v].mode, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Round robin with all requesters valid and rsp_ready high
    doReset();
    for (int i = 0; i < N_REQ; i++) begin
      applyStimulus(i, 8'($urandom), 3'($urandom), 2'($urandom));
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    lastCycle = -1;
    grants = 0;
    for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (expIds.size() == 0) begin
          checkOutput("rr_spurious_rsp", 32'd1, 32'd0);
        end else begin
          checkOutput("rr_rsp_id", 32'(rsp_id), 32'(expIds.pop_front()));
          checkOutput("rr_rsp_data", 32'(rsp_data), 32'(expData.pop_front()));
        end
      end
      if (req_ready != '0) begin
        w = refWinner(req_valid, model_ptr);
        checkOutput($sformatf("rr_grant%0d", grants), 32'(req_ready), 32'(1) << w);
        if (lastCycle >= 0) checkOutput("rr_spacing", 32'(cyc - lastCycle), 32'd3);
        lastCycle = cyc;
        expIds.push_back(w);
        expData.push_back(refShift(fd[w], int'(fa[w]), int'(fm[w])));
        model_ptr = (w + 1) % N_REQ;
        grants++;
      end
    end
    checkOutput("rr_grant_count", 32'(grants), 32'd5);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Back-pressure: hold the response for five cycles with others waiting
    applyStimulus(2, 8'h3C, 3'd2, 2'b10);
    req_valid = 4'b0100;
    waitReady(got);
    if (!got) checkOutput("bp_accept_timeout", 32'd0, 32'd1);
    checkOutput("bp_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 model_ptr = 3;
    applyStimulus(0, 8'h11, 3'd1, 2'b00);
    applyStimulus(1, 8'h22, 3'd1, 2'b00);
    applyStimulus(3, 8'h81, 3'd1, 2'b11);
    req_valid = 4'b1011;
    @(negedge clk);
    checkOutput("bp_exec_ready", 32'(req_ready), 32'd0);
    expv = refShift(8'h3C, 2, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_data", 32'(rsp_data), 32'(expv));
      checkOutput("bp_id", 32'(rsp_id), 32'd2);
      checkOutput("bp_ready_zero", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
    w = refWinner(req_valid, model_ptr);
    checkOutput("bp_release_grant", 32'(req_ready), 32'(1) << w);
    @(posedge clk);
    #1 req_valid = '0;
    model_ptr = (w + 1) % N_REQ;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Reset in EXEC drops the transaction and restarts the pointer at 0
    applyStimulus(2, 8'h5A, 3'd1, 2'b00);
    req_valid = 4'b0100;
    waitReady(got);
    if (!got) checkOutput("mid_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < N_REQ; i++) model_cnt[i] = 0;
    applyStimulus(1, 8'h0F, 3'd4, 2'b00);
    applyStimulus(3, 8'hF0, 3'd4, 2'b01);
    req_valid = 4'b1010;
    @(negedge clk);
    checkOutput("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("mid_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    model_ptr = 2;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_after_data", 32'(rsp_data), 32'(refShift(8'h0F, 4, 0)));
    checkOutput("mid_after_id", 32'(rsp_id), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Randomized transactions against the reference model
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N_REQ; i++) begin
        applyStimulus(i, 8'($urandom), 3'($urandom), 2'($urandom));
      end
      mask = 4'($urandom_range(1, 15));
      req_valid = mask;
      waitReady(got);
      if (!got) begin
        checkOutput("rand_accept_timeout", 32'd0, 32'd1);
        req_valid = '0;
        continue;
      end
      w = refWinner(mask, model_ptr);
      checkOutput("rand_grant", 32'(req_ready), 32'(1) << w);
      expv = refShift(fd[w], int'(fa[w]), int'(fm[w]));
      @(posedge clk);
      #1 req_valid = '0;
      model_ptr = (w + 1) % N_REQ;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rand_valid", 32'(rsp_valid), 32'd1);
      checkOutput("rand_data", 32'(rsp_data), 32'(expv));
      checkOutput("rand_id", 32'(rsp_id), 32'(w));
      holdData = rsp_data;
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checkOutput("rand_stall_data", 32'(rsp_data), 32'(expv));
        checkOutput("rand_stall_valid", 32'(rsp_valid), 32'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end

`ifdef BSA_STATS_EN
    // Grant counters
    doReset();
    for (int n = 0; n < 10; n++) runOne(1, 8'h01, 3'd1, 2'b00, 8'h02, "stat1");
    for (int n = 0; n < 3; n++) runOne(3, 8'h80, 3'd1, 2'b01, 8'h40, "stat3");
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      checkOutput($sformatf("grant_cnt%0d", i), 32'(grant_cnt[16*i +: 16]), 32'(model_cnt[i]));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
